// File: rtl/hyperbus_target.sv
// HyperBus device-side target: decodes the 48-bit CA phase, applies a fixed 2x
// initial latency and serves linear/wrapped bursts from word memory or CR0.
module hyperbus_target #(
  parameter int          ADDR_W    = 8,
  parameter int          LATENCY   = 6,
  parameter logic [15:0] CR0_RESET = 16'h8F1F
) (
  input  logic       wb_clk_i,
  input  logic       wb_rstn_i,
  input  logic       hb_rstn_i,
  input  logic       hb_csn_i,
  input  logic       hb_clk_i,
  input  logic       hb_rwds_i,
  output logic       hb_rwds_o,
  output logic       hb_rwds_oen,
  input  logic [7:0] hb_dq_i,
  output logic [7:0] hb_dq_o,
  output logic       hb_dq_oen,
  output logic       busy_o,
  output logic [2:0] dbg_state_o
);

  localparam int CNT_RAW = $clog2(2*LATENCY+1);
  localparam int CNT_W   = (CNT_RAW > 3) ? CNT_RAW : 3;
  localparam logic [CNT_W-1:0] CA_LAST  = CNT_W'(5);
  localparam logic [CNT_W-1:0] LAT_LAST = CNT_W'(2*LATENCY-1);
  localparam logic [CNT_W-1:0] LAT_DONE = CNT_W'(2*LATENCY);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CA    = 3'd1,
    S_LAT   = 3'd2,
    S_RDATA = 3'd3,
    S_WDATA = 3'd4
  } state_t;

  state_t            r_state, w_state_nxt;
  logic              r_clk_q;
  logic [CNT_W-1:0]  r_cnt, w_cnt_nxt;
  logic [39:0]       r_ca, w_ca_nxt;
  logic              r_rd, w_rd_nxt;
  logic              r_reg, w_reg_nxt;
  logic              r_lin, w_lin_nxt;
  logic [ADDR_W-1:0] r_addr, w_addr_nxt;
  logic [7:0]        r_hi, w_hi_nxt;
  logic              r_hi_mask, w_hi_mask_nxt;
  logic              r_have_hi, w_have_hi_nxt;
  logic              r_reg_done, w_reg_done_nxt;
  logic [7:0]        r_dq_o, w_dq_o_nxt;
  logic              r_dq_oen, w_dq_oen_nxt;
  logic              r_rwds_o, w_rwds_o_nxt;
  logic              r_rwds_oen, w_rwds_oen_nxt;
  logic [15:0]       r_cr0, w_cr0_nxt;
  logic [15:0]       r_mem [2**ADDR_W];

  logic              w_rise, w_fall, w_edge;
  logic [47:0]       w_ca_full;
  logic [31:0]       w_ca_addr;
  logic [ADDR_W-1:0] w_adv_addr;
  logic [15:0]       w_cur_word, w_next_word;
  logic              w_mem_we;

  // Linear bursts roll over the whole array; wrapped bursts stay in a 16-word group.
  function automatic logic [ADDR_W-1:0] adv_addr(input logic [ADDR_W-1:0] a,
                                                  input logic lin);
    if (lin) return a + ADDR_W'(1);
    else     return {a[ADDR_W-1:4], a[3:0] + 4'd1};
  endfunction

  assign w_rise      = hb_clk_i & ~r_clk_q;
  assign w_fall      = ~hb_clk_i & r_clk_q;
  assign w_edge      = w_rise | w_fall;
  assign w_ca_full   = {r_ca, hb_dq_i};
  assign w_ca_addr   = {w_ca_full[44:16], w_ca_full[2:0]};
  assign w_adv_addr  = adv_addr(r_addr, r_lin);
  assign w_cur_word  = r_reg ? r_cr0 : r_mem[r_addr];
  assign w_next_word = r_reg ? r_cr0 : r_mem[w_adv_addr];

  always_ff @(posedge wb_clk_i or negedge wb_rstn_i) begin
    if (!wb_rstn_i) begin
      r_state    <= S_IDLE;
      r_clk_q    <= 1'b0;
      r_cnt      <= '0;
      r_ca       <= '0;
      r_rd       <= 1'b0;
      r_reg      <= 1'b0;
      r_lin      <= 1'b0;
      r_addr     <= '0;
      r_hi       <= '0;
      r_hi_mask  <= 1'b0;
      r_have_hi  <= 1'b0;
      r_reg_done <= 1'b0;
      r_dq_o     <= '0;
      r_dq_oen   <= 1'b1;
      r_rwds_o   <= 1'b0;
      r_rwds_oen <= 1'b1;
      r_cr0      <= CR0_RESET;
    end else begin
      r_state    <= w_state_nxt;
      r_clk_q    <= hb_clk_i;
      r_cnt      <= w_cnt_nxt;
      r_ca       <= w_ca_nxt;
      r_rd       <= w_rd_nxt;
      r_reg      <= w_reg_nxt;
      r_lin      <= w_lin_nxt;
      r_addr     <= w_addr_nxt;
      r_hi       <= w_hi_nxt;
      r_hi_mask  <= w_hi_mask_nxt;
      r_have_hi  <= w_have_hi_nxt;
      r_reg_done <= w_reg_done_nxt;
      r_dq_o     <= w_dq_o_nxt;
      r_dq_oen   <= w_dq_oen_nxt;
      r_rwds_o   <= w_rwds_o_nxt;
      r_rwds_oen <= w_rwds_oen_nxt;
      r_cr0      <= w_cr0_nxt;
    end
  end

  // A set rwds bit masks that byte of the committed word.
  always_ff @(posedge wb_clk_i) begin
    if (w_mem_we) begin
      if (!r_hi_mask) r_mem[r_addr][15:8] <= r_hi;
      if (!hb_rwds_i) r_mem[r_addr][7:0]  <= hb_dq_i;
    end
  end

  always_comb begin
    w_state_nxt    = r_state;
    w_cnt_nxt      = r_cnt;
    w_ca_nxt       = r_ca;
    w_rd_nxt       = r_rd;
    w_reg_nxt      = r_reg;
    w_lin_nxt      = r_lin;
    w_addr_nxt     = r_addr;
    w_hi_nxt       = r_hi;
    w_hi_mask_nxt  = r_hi_mask;
    w_have_hi_nxt  = r_have_hi;
    w_reg_done_nxt = r_reg_done;
    w_dq_o_nxt     = r_dq_o;
    w_dq_oen_nxt   = r_dq_oen;
    w_rwds_o_nxt   = r_rwds_o;
    w_rwds_oen_nxt = r_rwds_oen;
    w_cr0_nxt      = r_cr0;
    w_mem_we       = 1'b0;

    if (!hb_rstn_i || hb_csn_i) begin
      w_state_nxt    = S_IDLE;
      w_dq_oen_nxt   = 1'b1;
      w_rwds_oen_nxt = 1'b1;
      w_have_hi_nxt  = 1'b0;
      w_reg_done_nxt = 1'b0;
      if (!hb_rstn_i) w_cr0_nxt = CR0_RESET;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          // rwds held high through CA tells the controller latency is doubled.
          w_state_nxt    = S_CA;
          w_cnt_nxt      = '0;
          w_rwds_oen_nxt = 1'b0;
          w_rwds_o_nxt   = 1'b1;
        end
        S_CA: begin
          if (w_edge) begin
            w_ca_nxt  = w_ca_full[39:0];
            w_cnt_nxt = r_cnt + 1'b1;
            if (r_cnt == CA_LAST) begin
              w_rwds_oen_nxt = 1'b1;
              w_rd_nxt       = w_ca_full[47];
              w_reg_nxt      = w_ca_full[46];
              w_lin_nxt      = w_ca_full[45];
              w_addr_nxt     = w_ca_addr[ADDR_W-1:0];
              w_cnt_nxt      = '0;
              w_have_hi_nxt  = 1'b0;
              w_reg_done_nxt = 1'b0;
              w_state_nxt    = (w_ca_full[46] && !w_ca_full[47]) ? S_WDATA : S_LAT;
            end
          end
        end
        S_LAT: begin
          if (w_rise && r_cnt != LAT_DONE) begin
            w_cnt_nxt = r_cnt + 1'b1;
            if (!r_rd && r_cnt == LAT_LAST) w_state_nxt = S_WDATA;
          end
          // Reads launch the first upper byte one edge ahead of the data rise.
          if (w_fall && r_rd && r_cnt == LAT_DONE) begin
            w_dq_oen_nxt   = 1'b0;
            w_dq_o_nxt     = w_cur_word[15:8];
            w_rwds_oen_nxt = 1'b0;
            w_rwds_o_nxt   = 1'b1;
            w_state_nxt    = S_RDATA;
          end
        end
        S_RDATA: begin
          if (w_rise) begin
            w_dq_o_nxt   = w_cur_word[7:0];
            w_rwds_o_nxt = 1'b0;
          end else if (w_fall) begin
            w_addr_nxt   = w_adv_addr;
            w_dq_o_nxt   = w_next_word[15:8];
            w_rwds_o_nxt = 1'b1;
          end
        end
        S_WDATA: begin
          if (!r_reg_done) begin
            if (w_rise) begin
              w_hi_nxt      = hb_dq_i;
              w_hi_mask_nxt = hb_rwds_i;
              w_have_hi_nxt = 1'b1;
            end else if (w_fall && r_have_hi) begin
              w_have_hi_nxt = 1'b0;
              w_addr_nxt    = w_adv_addr;
              if (r_reg) begin
                w_cr0_nxt      = {r_hi, hb_dq_i};
                w_reg_done_nxt = 1'b1;
              end else begin
                w_mem_we = 1'b1;
              end
            end
          end
        end
        default: w_state_nxt = S_IDLE;
      endcase
    end
  end

  assign hb_dq_o     = r_dq_o;
  assign hb_dq_oen   = r_dq_oen;
  assign hb_rwds_o   = r_rwds_o;
  assign hb_rwds_oen = r_rwds_oen;
  assign busy_o      = (r_state != S_IDLE);
  assign dbg_state_o = r_state;

endmodule

// File: tb/tb_hyperbus_target.sv
// Directed bench for hyperbus_target: drives the HyperBus pins as a controller
// would (hb_clk = wb_clk/4) and compares against hand-computed values.
module tb_hyperbus_target;

  logic       wb_clk  = 1'b0;
  logic       wb_rstn = 1'b0;
  logic       hb_rstn = 1'b1;
  logic       hb_csn  = 1'b1;
  logic       hb_clk  = 1'b0;
  logic       hb_rwds = 1'b0;
  logic [7:0] hb_dq   = 8'h00;
  logic       hb_rwds_o, hb_rwds_oen, hb_dq_oen, busy;
  logic [7:0] hb_dq_o;
  logic [2:0] dbg_state;

  int n_tests = 0;
  int n_fail  = 0;

  logic [15:0] rd_buf  [8];
  logic [15:0] wr_buf  [8];
  logic [1:0]  wr_mask [8];

  hyperbus_target #(.ADDR_W(8), .LATENCY(6), .CR0_RESET(16'h8F1F)) dut (
    .wb_clk_i    (wb_clk),
    .wb_rstn_i   (wb_rstn),
    .hb_rstn_i   (hb_rstn),
    .hb_csn_i    (hb_csn),
    .hb_clk_i    (hb_clk),
    .hb_rwds_i   (hb_rwds),
    .hb_rwds_o   (hb_rwds_o),
    .hb_rwds_oen (hb_rwds_oen),
    .hb_dq_i     (hb_dq),
    .hb_dq_o     (hb_dq_o),
    .hb_dq_oen   (hb_dq_oen),
    .busy_o      (busy),
    .dbg_state_o (dbg_state)
  );

  always #5 wb_clk = ~wb_clk;

  // ---------------- driver tasks ----------------
  task automatic hb_edge(input logic [7:0] dq, input logic rwds);
    @(negedge wb_clk);
    hb_clk  = ~hb_clk;
    hb_dq   = dq;
    hb_rwds = rwds;
    @(negedge wb_clk);
  endtask

  task automatic send_ca(input logic [47:0] ca);
    for (int i = 5; i >= 0; i--) hb_edge(ca[i*8 +: 8], 1'b0);
  endtask

  task automatic start_cmd(input logic [47:0] ca);
    @(negedge wb_clk);
    hb_csn = 1'b0;
    @(negedge wb_clk);
    send_ca(ca);
  endtask

  task automatic lat_pairs(input int n);
    for (int i = 0; i < n; i++) begin
      hb_edge(8'h00, 1'b0);
      hb_edge(8'h00, 1'b0);
    end
  endtask

  task automatic end_cmd();
    @(negedge wb_clk);
    hb_csn  = 1'b1;
    hb_clk  = 1'b0;
    hb_dq   = 8'h00;
    hb_rwds = 1'b0;
    repeat (2) @(negedge wb_clk);
  endtask

  task automatic write_cmd(input logic [47:0] ca, input logic is_reg, input int n);
    start_cmd(ca);
    if (!is_reg) lat_pairs(12);
    for (int k = 0; k < n; k++) begin
      hb_edge(wr_buf[k][15:8], wr_mask[k][1]);
      hb_edge(wr_buf[k][7:0],  wr_mask[k][0]);
    end
    end_cmd();
  endtask

  task automatic read_burst(input logic [47:0] ca, input int n);
    start_cmd(ca);
    lat_pairs(12);
    for (int k = 0; k < n; k++) begin
      rd_buf[k][15:8] = hb_dq_o;
      hb_edge(8'h00, 1'b0);
      rd_buf[k][7:0] = hb_dq_o;
      if (k < n - 1) hb_edge(8'h00, 1'b0);
    end
    end_cmd();
  endtask

  // ---------------- scenario tasks ----------------
  task automatic test_reset();
    wb_rstn = 1'b0;
    repeat (3) @(negedge wb_clk);
    n_tests++;
    if ({hb_dq_oen, hb_rwds_oen, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL reset_oen_busy: got %b expected 110", {hb_dq_oen, hb_rwds_oen, busy});
    end
    n_tests++;
    if ({hb_dq_o, hb_rwds_o} !== 9'h000) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected 000", {hb_dq_o, hb_rwds_o});
    end
    wb_rstn = 1'b1;
    repeat (2) @(negedge wb_clk);
    n_tests++;
    if (dbg_state !== 3'd0) begin
      n_fail++;
      $display("FAIL reset_idle_state: got %0d expected 0", dbg_state);
    end
  endtask

  task automatic test_linear();
    wr_buf[0] = 16'h1234; wr_mask[0] = 2'b00;
    wr_buf[1] = 16'h5678; wr_mask[1] = 2'b00;
    write_cmd(48'h2000_0000_0003, 1'b0, 2);

    @(negedge wb_clk);
    hb_csn = 1'b0;
    @(negedge wb_clk);
    n_tests++;
    if ({hb_rwds_oen, hb_rwds_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL ca_rwds_start: got %b expected 01", {hb_rwds_oen, hb_rwds_o});
    end
    for (int i = 5; i >= 1; i--) hb_edge(8'hA0 & {8{i == 5}} | 8'h03 & {8{i == 0}}, 1'b0);
    n_tests++;
    if ({hb_rwds_oen, hb_rwds_o} !== 2'b01) begin
      n_fail++;
      $display("FAIL ca_rwds_hold: got %b expected 01", {hb_rwds_oen, hb_rwds_o});
    end
    hb_edge(8'h03, 1'b0);
    n_tests++;
    if (hb_rwds_oen !== 1'b1) begin
      n_fail++;
      $display("FAIL ca_rwds_release: got %b expected 1", hb_rwds_oen);
    end
    lat_pairs(11);
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if (hb_dq_oen !== 1'b1) begin
      n_fail++;
      $display("FAIL lat_no_early_drive: got %b expected 1", hb_dq_oen);
    end
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if ({hb_dq_oen, hb_dq_o, hb_rwds_oen, hb_rwds_o} !== {1'b0, 8'h12, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_launch: got %b_%h_%b_%b expected 0_12_0_1",
               hb_dq_oen, hb_dq_o, hb_rwds_oen, hb_rwds_o);
    end
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if ({hb_dq_o, hb_rwds_o} !== {8'h34, 1'b0}) begin
      n_fail++;
      $display("FAIL rd_byte1: got %h/%b expected 34/0", hb_dq_o, hb_rwds_o);
    end
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if ({hb_dq_o, hb_rwds_o} !== {8'h56, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_byte2: got %h/%b expected 56/1", hb_dq_o, hb_rwds_o);
    end
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if ({hb_dq_o, hb_rwds_o, busy} !== {8'h78, 1'b0, 1'b1}) begin
      n_fail++;
      $display("FAIL rd_byte3: got %h/%b/%b expected 78/0/1", hb_dq_o, hb_rwds_o, busy);
    end
    end_cmd();
    n_tests++;
    if ({busy, hb_dq_oen} !== 2'b01) begin
      n_fail++;
      $display("FAIL rd_end_idle: got %b expected 01", {busy, hb_dq_oen});
    end
  endtask

  task automatic test_byte_mask();
    wr_buf[0] = 16'hAABB; wr_mask[0] = 2'b01;
    write_cmd(48'h2000_0000_0003, 1'b0, 1);
    read_burst(48'hA000_0000_0003, 1);
    n_tests++;
    if (rd_buf[0] !== 16'hAA34) begin
      n_fail++;
      $display("FAIL byte_mask: got %h expected AA34", rd_buf[0]);
    end
  endtask

  task automatic test_wrap();
    logic [15:0] exp_w [3];
    wr_buf[0] = 16'h00FF; wr_mask[0] = 2'b00;
    wr_buf[1] = 16'h0000; wr_mask[1] = 2'b00;
    write_cmd(48'h2000_001F_0007, 1'b0, 2);
    wr_buf[0] = 16'h000E;
    wr_buf[1] = 16'h000F;
    write_cmd(48'h2000_0001_0006, 1'b0, 2);
    read_burst(48'h8000_0001_0006, 3);
    exp_w[0] = 16'h000E; exp_w[1] = 16'h000F; exp_w[2] = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      n_tests++;
      if (rd_buf[k] !== exp_w[k]) begin
        n_fail++;
        $display("FAIL wrap_word%0d: got %h expected %h", k, rd_buf[k], exp_w[k]);
      end
    end
    read_burst(48'hA000_001F_0007, 2);
    n_tests++;
    if ({rd_buf[0], rd_buf[1]} !== 32'h00FF_0000) begin
      n_fail++;
      $display("FAIL linear_rollover: got %h %h expected 00ff 0000", rd_buf[0], rd_buf[1]);
    end
  endtask

  task automatic test_register();
    wr_buf[0] = 16'h8F17; wr_mask[0] = 2'b11;
    wr_buf[1] = 16'h1111; wr_mask[1] = 2'b00;
    write_cmd(48'h6000_0000_0000, 1'b1, 2);
    read_burst(48'hE000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h8F17) begin
      n_fail++;
      $display("FAIL reg_readback: got %h expected 8F17", rd_buf[0]);
    end
    read_burst(48'hE000_0000_0005, 2);
    n_tests++;
    if ({rd_buf[0], rd_buf[1]} !== 32'h8F17_8F17) begin
      n_fail++;
      $display("FAIL reg_any_addr: got %h %h expected 8f17 8f17", rd_buf[0], rd_buf[1]);
    end
    read_burst(48'hA000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h0000) begin
      n_fail++;
      $display("FAIL reg_no_mem_write: got %h expected 0000", rd_buf[0]);
    end
  endtask

  task automatic test_reset_mid_burst();
    start_cmd(48'hE000_0000_0000);
    lat_pairs(12);
    hb_edge(8'h00, 1'b0);
    n_tests++;
    if (hb_dq_oen !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_burst_driving: got %b expected 0", hb_dq_oen);
    end
    @(negedge wb_clk);
    wb_rstn = 1'b0;
    #1;
    n_tests++;
    if ({hb_dq_oen, hb_rwds_oen, busy} !== 3'b110) begin
      n_fail++;
      $display("FAIL async_reset: got %b expected 110", {hb_dq_oen, hb_rwds_oen, busy});
    end
    hb_csn = 1'b1;
    hb_clk = 1'b0;
    @(negedge wb_clk);
    wb_rstn = 1'b1;
    repeat (2) @(negedge wb_clk);
    read_burst(48'hE000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL cr0_after_reset: got %h expected 8F1F", rd_buf[0]);
    end
  endtask

  task automatic test_hb_reset();
    wr_buf[0] = 16'h1234; wr_mask[0] = 2'b00;
    write_cmd(48'h6000_0000_0000, 1'b1, 1);
    read_burst(48'hE000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h1234) begin
      n_fail++;
      $display("FAIL cr0_write2: got %h expected 1234", rd_buf[0]);
    end
    @(negedge wb_clk);
    hb_rstn = 1'b0;
    @(negedge wb_clk);
    hb_rstn = 1'b1;
    @(negedge wb_clk);
    read_burst(48'hE000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL hb_rstn_cr0: got %h expected 8F1F", rd_buf[0]);
    end
  endtask

  task automatic test_abort();
    wr_buf[0] = 16'h5555; wr_mask[0] = 2'b00;
    write_cmd(48'h2000_0004_0000, 1'b0, 1);
    start_cmd(48'h2000_0004_0000);
    lat_pairs(12);
    hb_edge(8'h99, 1'b0);
    @(negedge wb_clk);
    hb_csn = 1'b1;
    @(negedge wb_clk);
    n_tests++;
    if ({busy, dbg_state} !== 4'b0000) begin
      n_fail++;
      $display("FAIL abort_idle: got %b expected 0000", {busy, dbg_state});
    end
    hb_clk = 1'b0;
    hb_dq  = 8'h88;
    repeat (2) @(negedge wb_clk);
    read_burst(48'hA000_0004_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h5555) begin
      n_fail++;
      $display("FAIL abort_no_commit: got %h expected 5555", rd_buf[0]);
    end
    read_burst(48'hE000_0000_0000, 1);
    n_tests++;
    if (rd_buf[0] !== 16'h8F1F) begin
      n_fail++;
      $display("FAIL abort_next_ca: got %h expected 8F1F", rd_buf[0]);
    end
  endtask

  initial begin
    test_reset();
    test_linear();
    test_byte_mask();
    test_wrap();
    test_register();
    test_reset_mid_burst();
    test_hb_reset();
    test_abort();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/hyperbus_target.md
Name: hyperbus_target

Overview:
- Synthesizable HyperBus memory target: the device end of the HyperBus link that the HyperRAM controller drives.
- Decodes the 48-bit command/address (CA) phase, applies fixed 2x initial latency, and serves linear/wrapped bursts from an internal 16-bit-word memory plus one configuration register (CR0).
- Used as an on-chip loopback target for controller bring-up and for formal/sim benches.
- Oversamples the HyperBus pins with the system clock; the controller and the target share the same clock.

Parameters:
- ADDR_W, 8, word address width; memory depth is 2**ADDR_W 16-bit words.
- LATENCY, 6, initial latency in hb_clk cycles; the target always applies 2*LATENCY.
- CR0_RESET, 16'h8F1F, reset value of CR0.

Ports:
- wb_clk_i  in  1  system clock; hb_clk_i toggles no faster than wb_clk_i/4.
- wb_rstn_i  in  1  asynchronous active-low reset.
- hb_rstn_i  in  1  HyperBus device reset, active low, sampled synchronously.
- hb_csn_i  in  1  chip select, active low.
- hb_clk_i  in  1  HyperBus clock, sampled.
- hb_rwds_i  in  1  write byte mask from the controller (1 = masked).
- hb_rwds_o  out  1  latency indicator / read strobe.
- hb_rwds_oen  out  1  rwds output enable bar.
- hb_dq_i  in  8  DQ from the controller.
- hb_dq_o  out  8  DQ to the controller.
- hb_dq_oen  out  1  DQ output enable bar.
- busy_o  out  1  high whenever state != IDLE.

Behaviour:
- Reset values (wb_rstn_i low, async): hb_dq_o=0, hb_dq_oen=1, hb_rwds_o=0, hb_rwds_oen=1, busy_o=0, state=IDLE, CR0=CR0_RESET. Memory contents are not reset.
- Edge detection:
  - clk_q <= hb_clk_i each cycle.
  - rise = hb_clk_i & ~clk_q; fall = ~hb_clk_i & clk_q.
  - Inputs are captured in the same wb_clk_i cycle the edge is detected.
- hb_csn_i high or hb_rstn_i low (any state):
  - Next cycle: state=IDLE, hb_dq_oen=1, hb_rwds_oen=1.
  - Any incomplete word is discarded.
  - hb_rstn_i low also reloads CR0_RESET.
  - clk_q keeps tracking.
- IDLE: on hb_csn_i low -> CA, byte counter=0, hb_rwds_oen=0, hb_rwds_o=1 (signals 2x latency throughout CA).
- CA:
  - Capture hb_dq_i on each edge, MSB byte first, into ca[47:0]; 6 edges total (rise,fall x3).
  - On the 6th edge: hb_rwds_oen=1.
  - Field decode:
    - rd = ca[47]
    - reg = ca[46]
    - lin = ca[45]
    - addr = {ca[44:16], ca[2:0]} truncated to ADDR_W.
  - Next state:
    - reg & ~rd -> WDATA with no latency.
    - otherwise -> LAT, counter=0.
- LAT:
  - Count rising edges.
  - Write: leave on the 2*LATENCY-th rising edge; the next rising edge is the first data edge.
  - Read: on the falling edge after the 2*LATENCY-th rising edge, drive hb_dq_oen=0, hb_dq_o=word[15:8], hb_rwds_o=1 (launch one edge ahead), then -> RDATA.
- RDATA:
  - Read word = CR0 if reg, else mem[addr].
  - On each rise: drive word[7:0], hb_rwds_o=0.
  - On each fall: advance addr, drive next word[15:8], hb_rwds_o=1.
  - Continues until hb_csn_i rises.
- WDATA:
  - Rise captures the upper byte and its mask; fall captures the lower byte and its mask.
  - On fall, commit the word:
    - Memory: bytes with rwds=1 are skipped.
    - Register: rwds ignored, CR0 <= word.
  - Then advance addr.
  - A register write accepts one word; further edges are ignored until csn rises.
- Address advance:
  - lin=1: addr+1, modulo 2**ADDR_W.
  - lin=0: wrap within an aligned 16-word group; addr[3:0] increments, upper bits hold.
- Register space reads return CR0 for every address. Register space ignores addr.
- A read and a write commit never target the same word in one cycle (half-duplex), so there is no collision rule.

Test Plan:
- Reset mid-burst: assert wb_rstn_i low during RDATA -> same cycle hb_dq_oen=1, hb_rwds_oen=1, busy_o=0; CR0 reads back 8F1F afterwards.
- Linear write/read (LATENCY=6):
  - Write CA=48'h2000_0000_0003, data 1234,5678, rwds low -> mem[3]=1234, mem[4]=5678.
  - Read CA=48'hA000_0000_0003 -> hb_rwds_oen low with rwds=1 during CA; first upper byte driven after the 12th rising edge post-CA; DQ bytes 12,34,56,78 with rwds 1,0,1,0.
- Byte mask: write 0xAABB to addr 3 with rwds high on the lower byte -> mem[3]=AA34.
- Wrapped read:
  - Setup: mem[0x0E]=E, mem[0x0F]=F, mem[0x00]=0.
  - Stimulus: read start addr 0x0E, lin=0, 3 words.
  - Response: words E,F,0 (not 0x10).
  - Linear read from 0xFF with ADDR_W=8: 0xFF then 0x00.
- Register path: write CA=48'h6000_0000_0000, word 0x8F17 with no latency -> CR0=8F17; register read returns 8F17 after 12-cycle latency.
- Abort: raise hb_csn_i after the upper byte of a write word -> that word is not committed, busy_o low next cycle, next transaction decodes its CA cleanly.
